// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets (relative to BASE), the STATUS bit positions,
// the engine state encoding and a helper that clamps the bit divisor.
package uart_tx_dev_pkg;

  // Register word offsets from BASE.
  localparam logic [31:0] RegTxdata  = 32'd0;
  localparam logic [31:0] RegStatus  = 32'd1;
  localparam logic [31:0] RegDivisor = 32'd2;

  // STATUS bit positions; count occupies [15:8].
  localparam int unsigned StatEmpty = 0;
  localparam int unsigned StatFull  = 1;
  localparam int unsigned StatBusy  = 2;
  localparam int unsigned StatOvf   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // A zero divisor would stall the bit counter, so it is stored as 1.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/uart_tx_dev_fifo.sv
// Synchronous DEPTH x 8 FIFO feeding the transmit engine.
// Ports: clk, reset_n (async active-low), push/wdata (write side),
// pop/rdata (read side, rdata shows the head entry combinationally),
// full, empty and count (number of stored entries).
// A push while full is accepted only if a pop happens in the same cycle.
module uart_tx_dev_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign rdata   = mem_q[rptr_q[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// Ports: clk, reset_n (async active-low), strobe/rw/addr (bus cycle),
// data (bidirectional bus, driven only on a read hit), txd (serial out,
// idle high). Registers at BASE+0 TXDATA, BASE+1 STATUS, BASE+2 DIVISOR.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h200,
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd217
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic        rw,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  output logic        txd
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            hit_tx, hit_st, hit_dv, hit;
  logic [31:0]     rdata;
  logic [15:0]     divisor_q;
  logic            ovf_q;
  tx_state_e       state_q;
  logic [15:0]     cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            txd_q;
  logic            push, pop, busy;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CW-1:0]   fifo_count;
  logic            unused_data;

  assign hit_tx = strobe && (addr == BASE + RegTxdata);
  assign hit_st = strobe && (addr == BASE + RegStatus);
  assign hit_dv = strobe && (addr == BASE + RegDivisor);
  assign hit    = hit_tx || hit_st || hit_dv;

  assign push        = hit_tx && rw;
  assign busy        = (state_q != StIdle);
  assign unused_data = ^data[31:16];

  // Pop at the same edge the engine moves into START.
  assign pop = !fifo_empty &&
               ((state_q == StIdle) || ((state_q == StStop) && (cnt_q == 16'd0)));

  uart_tx_dev_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (data[7:0]),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    rdata = '0;
    if (hit_st) begin
      rdata[15:8]      = 8'(fifo_count);
      rdata[StatOvf]   = ovf_q;
      rdata[StatBusy]  = busy;
      rdata[StatFull]  = fifo_full;
      rdata[StatEmpty] = fifo_empty;
    end else if (hit_dv) begin
      rdata[15:0] = divisor_q;
    end
  end

  assign data = (hit && !rw) ? rdata : 32'bz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor_q <= DIV_RESET;
      ovf_q     <= 1'b0;
    end else begin
      if (hit_dv && rw) divisor_q <= clamp_div(data[15:0]);
      if (push && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end else if (hit_st && rw && data[StatOvf]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Engine. txd_q follows the state one cycle later, so the line drops low
  // the edge after the pop and every bit still lasts exactly DIV cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StStart: txd_q <= 1'b0;
        StData:  txd_q <= shift_q[0];
        default: txd_q <= 1'b1;
      endcase

      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q <= StStart;
            shift_q <= fifo_rdata;
            cnt_q   <= divisor_q - 16'd1;
          end
        end
        StStart: begin
          if (cnt_q == 16'd0) begin
            state_q <= StData;
            bit_q   <= 3'd0;
            cnt_q   <= divisor_q - 16'd1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StData: begin
          if (cnt_q == 16'd0) begin
            cnt_q <= divisor_q - 16'd1;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StStop: begin
          if (cnt_q == 16'd0) begin
            if (!fifo_empty) begin
              state_q <= StStart;
              shift_q <= fifo_rdata;
              cnt_q   <= divisor_q - 16'd1;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed self-checking bench for uart_tx_dev.
module tb_uart_tx_dev;

  localparam logic [31:0] BASE = 32'h200;

  logic        clk;
  logic        reset_n;
  logic        strobe;
  logic        rw;
  logic [31:0] addr;
  logic        tb_drive;
  logic [31:0] tb_wdata;
  wire  [31:0] data;
  logic        txd;

  int checks;
  int errors;

  assign data = tb_drive ? tb_wdata : 32'bz;

  uart_tx_dev #(
    .BASE      (BASE),
    .DEPTH     (8),
    .DIV_RESET (16'd217)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (strobe),
    .rw      (rw),
    .addr    (addr),
    .data    (data),
    .txd     (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for bit slot idx of an 8N1 frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // One write cycle; the register update happens at the posedge inside.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    strobe   = 1'b1;
    rw       = 1'b1;
    addr     = a;
    tb_wdata = v;
    tb_drive = 1'b1;
    @(posedge clk);
    #1;
    strobe   = 1'b0;
    rw       = 1'b0;
    tb_drive = 1'b0;
  endtask

  // Combinational read performed within the current low clock phase.
  task automatic bus_read_now(input logic [31:0] a, output logic [31:0] v);
    strobe = 1'b1;
    rw     = 1'b0;
    addr   = a;
    #1;
    v      = data;
    strobe = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    bus_read_now(a, v);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL reset_txd: got %b want 1", txd);
    end
    reset_n = 1'b1;
    bus_read(BASE + 1, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++;
      $display("FAIL reset_status: got %h want 00000001", v);
    end
    bus_read(BASE + 2, v);
    checks++;
    if (v !== 32'd217) begin
      errors++;
      $display("FAIL reset_divisor: got %0d want 217", v);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle_txd cycle %0d: got %b want 1", i, txd);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] v;
    bus_write(BASE + 2, 32'd4);
    bus_write(BASE + 0, 32'h0000_00A5);
    // Two low phases of high line before the start bit (pop edge, then lag).
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin
        errors++;
        $display("FAIL a5_prestart %0d: got %b want 1", i, txd);
      end
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (txd !== frame_bit(8'hA5, k / 4)) begin
        errors++;
        $display("FAIL a5_frame cycle %0d: got %b want %b", k, txd, frame_bit(8'hA5, k / 4));
      end
      if (k == 20) begin
        bus_read_now(BASE + 1, v);
        checks++;
        if (v !== 32'h0000_0005) begin
          errors++;
          $display("FAIL a5_status_busy: got %h want 00000005", v);
        end
      end
    end
    bus_read(BASE + 1, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++;
      $display("FAIL a5_status_done: got %h want 00000001", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [7:0]  bytes [3];
    bytes[0] = 8'h55;
    bytes[1] = 8'h0F;
    bytes[2] = 8'hF0;
    bus_write(BASE + 2, 32'd2);
    for (int i = 0; i < 3; i++) bus_write(BASE + 0, {24'h0, bytes[i]});
    // First write was two edges ago, so the next low phase is start-bit cycle 0.
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++;
      if (txd !== frame_bit(bytes[k / 20], (k % 20) / 2)) begin
        errors++;
        $display("FAIL b2b_frame cycle %0d: got %b want %b", k, txd,
                 frame_bit(bytes[k / 20], (k % 20) / 2));
      end
      if (k == 0 || k == 30 || k == 57) begin
        bus_read_now(BASE + 1, v);
        checks++;
        if (v[2] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy cycle %0d: got %b want 1", k, v[2]);
        end
      end
    end
    @(negedge clk);
    bus_read_now(BASE + 1, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++;
      $display("FAIL b2b_status_done: got %h want 00000001", v);
    end
  endtask

  task automatic test_overflow_and_reset();
    logic [31:0] v;
    bus_write(BASE + 2, 32'd1000);
    // First byte 0x00 keeps the line low during DATA so reset is visible.
    for (int i = 0; i < 10; i++) bus_write(BASE + 0, 32'(i * 16));
    bus_read(BASE + 1, v);
    checks++;
    if (v !== 32'h0000_080E) begin
      errors++;
      $display("FAIL ovf_status: got %h want 0000080E", v);
    end
    bus_write(BASE + 1, 32'h0000_0008);
    bus_read(BASE + 1, v);
    checks++;
    if (v !== 32'h0000_0806) begin
      errors++;
      $display("FAIL ovf_clear: got %h want 00000806", v);
    end
    repeat (1300) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL mid_data_txd: got %b want 0", txd);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_txd: got %b want 1", txd);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(BASE + 1, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++;
      $display("FAIL post_reset_status: got %h want 00000001", v);
    end
    bus_read(BASE + 2, v);
    checks++;
    if (v !== 32'd217) begin
      errors++;
      $display("FAIL post_reset_divisor: got %0d want 217", v);
    end
    bus_read(BASE + 3, v);
    checks++;
    // Undriven bus: high-Z in four-state, or zero with two-state resolution.
    if ((v !== 32'bz) && (v !== 32'h0)) begin
      errors++;
      $display("FAIL unmapped_read: got %h want zzzzzzzz", v);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] v;
    bus_write(BASE + 2, 32'd0);
    bus_read(BASE + 2, v);
    checks++;
    if (v !== 32'd1) begin
      errors++;
      $display("FAIL div_zero_readback: got %0d want 1", v);
    end
    bus_write(BASE + 0, 32'h0000_00FF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin
        errors++;
        $display("FAIL ff_prestart %0d: got %b want 1", i, txd);
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (txd !== frame_bit(8'hFF, k)) begin
        errors++;
        $display("FAIL ff_frame cycle %0d: got %b want %b", k, txd, frame_bit(8'hFF, k));
      end
    end
    bus_read(BASE + 1, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++;
      $display("FAIL ff_status_done: got %h want 00000001", v);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    strobe   = 1'b0;
    rw       = 1'b0;
    addr     = '0;
    tb_drive = 1'b0;
    tb_wdata = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow_and_reset();
    test_div_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_dev.md
# uart_tx_dev

Memory-mapped UART transmitter that responds on the Tenyr core's data bus alongside the block RAM and Seg7. Core stores to its registers push bytes into a small FIFO. A bit-serial engine drains the FIFO onto a single 8N1 line, LSB first, at a programmable divisor. Register reads return FIFO/engine status so firmware can poll before writing.

## Interface
- BASE, 32'h200: byte-independent word address of register 0; device occupies BASE..BASE+2.
- DEPTH, 8: FIFO entries, power of two, ≥2.
- DIV_RESET, 16'd217: reset value of DIVISOR (clk cycles per bit).
- clk  in  1  core clock (clk_core).
- reset_n  in  1  asynchronous, active-low reset.
- strobe  in  1  bus cycle valid.
- rw  in  1  1 = write (core drives data), 0 = read.
- addr  in  32  word address.
- data  inout  32  bus data; driven only when strobe && !rw && address hits, else high-Z.
- txd  out  1  serial output, idle high.

## Operation
- Hit = strobe && addr ∈ {BASE, BASE+1, BASE+2}; all other addresses ignored, data stays Z.
- BASE+0 TXDATA: write pushes data[7:0]; read returns 0.
- BASE+1 STATUS: read {16'b0, count[7:0], 4'b0, ovf, busy, full, empty}; write with data[3]=1 clears ovf, other bits ignored.
- BASE+2 DIVISOR: rw, data[15:0], upper bits read 0; written 0 is stored as 1.
- Push when full: byte dropped, ovf set (sticky). Push and pop in same cycle while full: push accepted, count unchanged.
- Engine states IDLE, START, DATA, STOP. IDLE→START when FIFO non-empty (pop that cycle). START→DATA after DIV cycles. DATA shifts 8 bits, DIV cycles each, then →STOP. STOP lasts DIV cycles, then →START (pop) if non-empty, else →IDLE.
- busy = state ≠ IDLE. txd: 1 in IDLE/STOP, 0 in START, shift[0] in DATA; txd is a registered output.
- Bit counter reloads from DIVISOR at each bit boundary; a DIVISOR write mid-frame affects the next bit, never truncates the current one.

## Timing
- Register writes take effect at the posedge where strobe && rw && hit; reads are combinational from current registers (zero wait states).
- FIFO push-to-start: write at edge N (FIFO empty, IDLE) → pop at edge N+1 → txd low after edge N+2.
- Frame = exactly 10×DIV cycles; back-to-back frames have no idle gap.
- STATUS reflects a push one cycle after the write edge.
- Reset (async, any time incl. mid-frame): txd=1 immediately, FIFO empty, count=0, ovf=0, state IDLE, DIVISOR=DIV_RESET, data=Z.

## Structure
- Shared header uart.vh: register offsets (TXDATA=0, STATUS=1, DIVISOR=2), STATUS bit positions, state encodings.
- Sub-module tx_fifo: synchronous DEPTH×8 FIFO with push/pop/full/empty/count; power-of-two pointers with extra wrap bit.
- Top: bus decode, tristate driver, DIVISOR/ovf registers, engine FSM, bit counter, shift register.

## Test plan
- Reset then read STATUS → 32'h00000001; read DIVISOR → 217; txd=1 throughout.
- DIVISOR=4, write 8'hA5 → txd: 0 for 4 cycles, bits 1,0,1,0,0,1,0,1 4 cycles each, 1 for 4 cycles; frame 40 cycles.
- DIVISOR=2, write 3 bytes back-to-back → 60 continuous cycles of framing, no idle cycle between stop and next start; STATUS busy=1 until end.
- Stall engine with DIVISOR=1000, write 10 bytes with DEPTH=8 → full=1, ovf=1, count=8 after 1 pop-compensated accept; write STATUS 8 → ovf=0.
- Assert reset_n low mid-DATA → txd=1 same cycle, STATUS=1 after release; read of unmapped BASE+3 → data stays Z.
- Write DIVISOR=0 → reads back 1; frame of 0xFF lasts 10 cycles.
